// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, coordinate type and the sync/blank bundle
// passed between the raster counter and its output delay line.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic blank;
    logic hs;
    logic vs;
  } sync_t;

  // Half-open window test lo <= v < hi
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register that re-times blank/hs/vs to line up with the
// renderers' ROM-read-plus-register pipeline. Advances every clock.
module vga_sync_delay #(
  parameter int   PIPE_DELAY = 2,
  parameter logic SYNC_POL   = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  vga_pkg::sync_t i_sync,
  output vga_pkg::sync_t o_sync
);
  import vga_pkg::*;

  localparam sync_t RST_VAL = sync_t'{blank: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL};

  sync_t r_pipe [PIPE_DELAY];

  // Shift stage 0 from the live bundle; every stage clears on reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        r_pipe[i] <= RST_VAL;
      end
    end else begin
      r_pipe[0] <= i_sync;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_sync = r_pipe[PIPE_DELAY-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: DrawX/DrawY counters, blank, hs/vs, line/frame strobes,
// frame counter and pipeline-aligned delayed sync/blank copies.
module vga_timing_gen #(
  parameter int   H_VISIBLE  = vga_pkg::H_VISIBLE,
  parameter int   H_FRONT    = vga_pkg::H_FRONT,
  parameter int   H_SYNC     = vga_pkg::H_SYNC,
  parameter int   H_BACK     = vga_pkg::H_BACK,
  parameter int   V_VISIBLE  = vga_pkg::V_VISIBLE,
  parameter int   V_FRONT    = vga_pkg::V_FRONT,
  parameter int   V_SYNC     = vga_pkg::V_SYNC,
  parameter int   V_BACK     = vga_pkg::V_BACK,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   PIPE_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       hs_d,
  output logic       vs_d,
  output logic       blank_d,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);
  import vga_pkg::*;

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_MAX  = coord_t'(H_TOT - 1);
  localparam coord_t V_MAX  = coord_t'(V_TOT - 1);
  localparam coord_t H_VIS  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS  = coord_t'(V_VISIBLE);
  localparam coord_t HS_LO  = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_HI  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_LO  = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_HI  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic SYNC_IDLE = ~SYNC_POL;

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counters");
  end
  if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be 1..4");
  end

  coord_t     r_x;
  coord_t     r_y;
  logic       r_blank;
  logic       r_hs;
  logic       r_vs;
  logic       r_line_start;
  logic       r_frame_start;
  logic [7:0] r_frame_count;

  coord_t w_x_next;
  coord_t w_y_next;
  logic   w_x_wrap;
  logic   w_frame_wrap;
  sync_t  w_sync;
  sync_t  w_sync_d;

  // Next raster position; levels are decoded from it so they share DrawX/DrawY timing
  always_comb begin
    w_x_wrap     = (r_x == H_MAX);
    w_frame_wrap = w_x_wrap && (r_y == V_MAX);
    w_x_next     = r_x;
    w_y_next     = r_y;
    if (w_x_wrap) begin
      w_x_next = coord_t'(0);
      if (r_y == V_MAX) begin
        w_y_next = coord_t'(0);
      end else begin
        w_y_next = r_y + coord_t'(1);
      end
    end else begin
      w_x_next = r_x + coord_t'(1);
    end
  end

  // Counters park at the last pixel in reset so the first step lands on (0,0)
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x           <= H_MAX;
      r_y           <= V_MAX;
      r_blank       <= 1'b0;
      r_hs          <= SYNC_IDLE;
      r_vs          <= SYNC_IDLE;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= 8'd0;
    end else if (pix_en) begin
      r_x           <= w_x_next;
      r_y           <= w_y_next;
      r_blank       <= (w_x_next < H_VIS) && (w_y_next < V_VIS);
      r_hs          <= in_window(w_x_next, HS_LO, HS_HI) ? SYNC_POL : SYNC_IDLE;
      r_vs          <= in_window(w_y_next, VS_LO, VS_HI) ? SYNC_POL : SYNC_IDLE;
      r_line_start  <= w_x_wrap;
      r_frame_start <= w_frame_wrap;
      if (w_frame_wrap) begin
        r_frame_count <= r_frame_count + 8'd1;
      end else begin
        r_frame_count <= r_frame_count;
      end
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign w_sync = sync_t'{blank: r_blank, hs: r_hs, vs: r_vs};

  vga_sync_delay #(
    .PIPE_DELAY (PIPE_DELAY),
    .SYNC_POL   (SYNC_POL)
  ) u_sync_delay (
    .i_clk   (vga_clk),
    .i_rst_n (reset_n),
    .i_sync  (w_sync),
    .o_sync  (w_sync_d)
  );

  assign DrawX       = r_x;
  assign DrawY       = r_y;
  assign blank       = r_blank;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign hs_d        = w_sync_d.hs;
  assign vs_d        = w_sync_d.vs;
  assign blank_d     = w_sync_d.blank;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates VGA raster timing: pixel/line counters, DrawX/DrawY coordinates, display-enable `blank`, and hsync/vsync for 640x480@60. It is the producer side of the DrawX/DrawY/blank interface that the sprite drawers and ROM/palette renderers consume. It also provides sync/blank copies delayed to match the renderers' ROM-read-plus-register pipeline, plus frame/line strobes for game-logic update.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hs/vs (0 = active-low)
PIPE_DELAY, 2, vga_clk cycles of delay on hs_d/vs_d/blank_d; legal range 1..4

Ports:
vga_clk  in  1  pixel-domain clock
reset_n  in  1  asynchronous reset, active-low
pix_en  in  1  pixel advance enable; counters step only when 1
DrawX  out  10  horizontal counter, 0..H_TOTAL-1
DrawY  out  10  vertical counter, 0..V_TOTAL-1
blank  out  1  1 = visible region (display enable), aligned to DrawX/DrawY
hs  out  1  hsync, aligned to DrawX/DrawY
vs  out  1  vsync, aligned to DrawX/DrawY
hs_d  out  1  hs delayed PIPE_DELAY vga_clk cycles
vs_d  out  1  vs delayed PIPE_DELAY vga_clk cycles
blank_d  out  1  blank delayed PIPE_DELAY vga_clk cycles
line_start  out  1  one-cycle pulse when DrawX becomes 0
frame_start  out  1  one-cycle pulse when (DrawX,DrawY) becomes (0,0)
frame_count  out  8  frames started since reset, modulo 256

Behaviour:
- H_TOTAL = sum of H_* parameters (800). V_TOTAL = sum of V_* parameters (525). All outputs are registered.
- Reset (async assert, sync release):
  - DrawX = H_TOTAL-1 and DrawY = V_TOTAL-1, so reset parks the counters in blanking.
  - blank = 0, hs = vs = ~SYNC_POL, line_start = frame_start = 0, frame_count = 0.
  - Delay-line stages reset to blank=0 and syncs inactive.
- Step: on a vga_clk edge with pix_en=1:
  - DrawX = (DrawX == H_TOTAL-1) ? 0 : DrawX+1.
  - On X wrap: DrawY = (DrawY == V_TOTAL-1) ? 0 : DrawY+1.
  - With pix_en=0, all counters and level outputs hold.
- Level outputs are computed from the next-state counters, so they are coincident with DrawX/DrawY (zero skew):
  - blank = (DrawX < H_VISIBLE) && (DrawY < V_VISIBLE).
  - hs = SYNC_POL when H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751), else ~SYNC_POL.
  - vs = SYNC_POL when V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491), else ~SYNC_POL.
- Strobes:
  - line_start = 1 for exactly one vga_clk cycle, on the step that sets DrawX to 0.
  - It is 0 on every other cycle, including held cycles with pix_en=0.
  - frame_start follows the same rule for the step that sets DrawX=0 and DrawY=0. It coincides with line_start.
  - frame_count increments on the same step and wraps 255 -> 0.
- First step after reset release: (H_TOTAL-1, V_TOTAL-1) -> (0,0), with frame_start=1, line_start=1, frame_count=1, blank=1.
- Delay line:
  - hs_d/vs_d/blank_d equal hs/vs/blank from PIPE_DELAY vga_clk cycles earlier.
  - The delay counts vga_clk cycles and is not gated by pix_en, because it matches the renderer's clocked ROM plus RGB register.
- Reset mid-frame: asynchronous return to the reset state, including the delay-line contents. There is no partial-frame strobe.
- Counter width: 10 bits. H_TOTAL and V_TOTAL must be <= 1024. This is checked by an elaboration-time assertion, as is the PIPE_DELAY range.

Decomposition:
- Package vga_pkg holds:
  - default timing localparams: H_VISIBLE through V_BACK, H_TOTAL, V_TOTAL;
  - typedef coord_t = logic [9:0];
  - packed struct sync_t {blank, hs, vs}.
- One sub-module, vga_sync_delay: a PIPE_DELAY-deep shift register of sync_t with asynchronous active-low reset to {0, ~SYNC_POL, ~SYNC_POL}.

Test Plan:
- Reset hold, then release with pix_en=1 -> during reset DrawX=799, DrawY=524, blank=0, hs=vs=1. First edge after release gives DrawX=0, DrawY=0, blank=1, frame_start=1, frame_count=1.
- Full line with pix_en=1 -> blank=1 for DrawX 0..639, 0 for 640..799. hs=0 exactly for DrawX 656..751. line_start pulses once per 800 cycles.
- Full frame -> vs=0 exactly for DrawY 490..491. frame_start every 420000 cycles. frame_count reaches 0 after 256 frames.
- pix_en toggling 1,0 (half rate) -> counters advance every other cycle. Each strobe is still exactly one vga_clk wide. A line takes 1600 cycles.
- PIPE_DELAY=2 -> blank_d matches blank shifted exactly 2 vga_clk cycles, checked at the 639->640 transition.
- Assert reset_n low at DrawX=300, DrawY=200 -> outputs immediately show the reset values. No frame_start while reset is held. Restart is identical to the first scenario.
